axi_err_slave: RTL and testbench

//   Parametrised AXI4 error-responder slave. Absorbs every transaction the

---
 rtl/axi_err_slave_if.sv | 70 +++++++
 rtl/axi_err_slave.sv | 198 +++++++++++++++++++
 tb/tb_axi_err_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_err_slave_if.sv
// AXI4 bus bundle between the interconnect (master side) and the error responder (slave side).
interface axi_err_slave_if #(
   parameter int unsigned ID_W   = 8,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 8
);
   localparam int unsigned STRB_W = DATA_W / 8;

   // read address
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [LEN_W-1:0]  arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   // read data
   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;
   // write address
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [LEN_W-1:0]  awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;
   // write data
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   // write response
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_err_slave.sv
// AXI4 error-responder slave: answers every read/write burst with a fixed error
// response, tracks bursts per beat, and keeps saturating error counters plus the
// address of the most recently accepted request.
module axi_err_slave #(
   parameter int unsigned ID_W   = 8,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 8,
   parameter logic [1:0]  RESP   = 2'b11,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   axi_err_slave_if.slave      bus,
   input  logic                err_clr,
   output logic [CNT_W-1:0]    rd_err_cnt,
   output logic [CNT_W-1:0]    wr_err_cnt,
   output logic [ADDR_W-1:0]   last_err_addr
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   r_state_t          r_state;
   w_state_t          w_state;

   logic              arready_q;
   logic              rvalid_q;
   logic [ID_W-1:0]   rid_q;
   logic [1:0]        rresp_q;
   logic              rlast_q;
   logic [LEN_W-1:0]  rlen_q;
   logic [LEN_W-1:0]  rcnt_q;

   logic              awready_q;
   logic              wready_q;
   logic              bvalid_q;
   logic [ID_W-1:0]   wid_q;
   logic [ID_W-1:0]   bid_q;
   logic [1:0]        bresp_q;
   logic [LEN_W-1:0]  wlen_q;
   logic [LEN_W-1:0]  wcnt_q;

   logic              ar_hs_c;
   logic              aw_hs_c;
   logic              w_hs_c;
   logic              rd_done_c;
   logic              wr_done_c;
   logic              unused_c;

   assign ar_hs_c   = bus.arvalid & arready_q;
   assign aw_hs_c   = bus.awvalid & awready_q;
   assign w_hs_c    = bus.wvalid  & wready_q;
   assign rd_done_c = rvalid_q & bus.rready & rlast_q;
   assign wr_done_c = bvalid_q & bus.bready;

   // Size/burst qualifiers and write data are accepted but have no effect.
   assign unused_c = ^{bus.arsize, bus.arburst, bus.awsize, bus.awburst, bus.wdata, bus.wstrb};

   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rid     = rid_q;
   assign bus.rdata   = DATA_W'(0);
   assign bus.rresp   = rresp_q;
   assign bus.rlast   = rlast_q;
   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bid     = bid_q;
   assign bus.bresp   = bresp_q;

   // Read FSM: accept AR, then stream LEN+1 zero-data error beats; RLAST is precomputed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs_c) begin
                  r_state   <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rid_q     <= bus.arid;
                  rresp_q   <= RESP;
                  rlen_q    <= bus.arlen;
                  rcnt_q    <= '0;
                  rlast_q   <= (bus.arlen == '0);
               end
            end
            R_DATA: begin
               if (rvalid_q && bus.rready) begin
                  if (rlast_q) begin
                     r_state   <= R_IDLE;
                     arready_q <= 1'b1;
                     rvalid_q  <= 1'b0;
                     rid_q     <= '0;
                     rresp_q   <= '0;
                     rlast_q   <= 1'b0;
                  end else begin
                     rcnt_q  <= LEN_W'(rcnt_q + 1'b1);
                     rlast_q <= (LEN_W'(rcnt_q + 1'b1) == rlen_q);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Write FSM: accept AW, sink beats until WLAST or the beat count is reached, then respond.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         wid_q     <= '0;
         bid_q     <= '0;
         bresp_q   <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs_c) begin
                  w_state   <= W_DATA;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wid_q     <= bus.awid;
                  wlen_q    <= bus.awlen;
                  wcnt_q    <= '0;
               end
            end
            W_DATA: begin
               if (w_hs_c) begin
                  // A late or missing WLAST is covered by the beat count.
                  if (bus.wlast || (wcnt_q == wlen_q)) begin
                     w_state  <= W_RESP;
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bid_q    <= wid_q;
                     bresp_q  <= RESP;
                  end else begin
                     wcnt_q <= LEN_W'(wcnt_q + 1'b1);
                  end
               end
            end
            W_RESP: begin
               if (wr_done_c) begin
                  w_state   <= W_IDLE;
                  awready_q <= 1'b1;
                  bvalid_q  <= 1'b0;
                  bid_q     <= '0;
                  bresp_q   <= '0;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Saturating completed-read counter; clear wins over a same-cycle completion.
   always_ff @(posedge clk) begin
      if (rst || err_clr) begin
         rd_err_cnt <= '0;
      end else if (rd_done_c && (rd_err_cnt != CNT_MAX)) begin
         rd_err_cnt <= CNT_W'(rd_err_cnt + 1'b1);
      end
   end

   // Saturating completed-write counter; clear wins over a same-cycle completion.
   always_ff @(posedge clk) begin
      if (rst || err_clr) begin
         wr_err_cnt <= '0;
      end else if (wr_done_c && (wr_err_cnt != CNT_MAX)) begin
         wr_err_cnt <= CNT_W'(wr_err_cnt + 1'b1);
      end
   end

   // Address of the latest accepted request; AR wins a same-cycle tie with AW.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_err_addr <= '0;
      end else if (ar_hs_c) begin
         last_err_addr <= bus.araddr;
      end else if (aw_hs_c) begin
         last_err_addr <= bus.awaddr;
      end
   end
endmodule

// File: tb/tb_axi_err_slave.sv
// Directed bench for axi_err_slave: reset, read/write bursts, concurrency,
// early WLAST, mid-burst reset, counter saturation and clear priority.
module tb_axi_err_slave;
   localparam int unsigned ID_W   = 8;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              err_clr = 1'b0;
   logic [CNT_W-1:0]  rd_err_cnt;
   logic [CNT_W-1:0]  wr_err_cnt;
   logic [ADDR_W-1:0] last_err_addr;

   int checks = 0;
   int errors = 0;

   axi_err_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   axi_err_slave #(
      .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
      .RESP(2'b11), .CNT_W(CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .err_clr       (err_clr),
      .rd_err_cnt    (rd_err_cnt),
      .wr_err_cnt    (wr_err_cnt),
      .last_err_addr (last_err_addr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'b01;
      bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'b01;
      bus.awvalid = 1'b0;
      bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;

      // 1: reset held two cycles
      tick(); tick();
      check("rst_arready", 32'(bus.arready), 32'd1);
      check("rst_awready", 32'(bus.awready), 32'd1);
      check("rst_rvalid",  32'(bus.rvalid),  32'd0);
      check("rst_bvalid",  32'(bus.bvalid),  32'd0);
      check("rst_wready",  32'(bus.wready),  32'd0);
      check("rst_rdcnt",   32'(rd_err_cnt),  32'd0);
      check("rst_wrcnt",   32'(wr_err_cnt),  32'd0);
      check("rst_addr",    32'(last_err_addr), 32'd0);
      rst = 1'b0;

      // 2: read burst ID=5 LEN=3 with RREADY high
      bus.arvalid = 1'b1; bus.arid = 8'h05; bus.arlen = 8'd3; bus.araddr = 32'h0000_1000;
      bus.rready = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      check("rd_arready_busy", 32'(bus.arready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rd_rvalid_b%0d", i), 32'(bus.rvalid), 32'd1);
         check($sformatf("rd_rid_b%0d", i),    32'(bus.rid),    32'h5);
         check($sformatf("rd_rresp_b%0d", i),  32'(bus.rresp),  32'd3);
         check($sformatf("rd_rdata_b%0d", i),  32'(bus.rdata),  32'd0);
         check($sformatf("rd_rlast_b%0d", i),  32'(bus.rlast),  (i == 3) ? 32'd1 : 32'd0);
         tick();
      end
      check("rd_rvalid_done", 32'(bus.rvalid), 32'd0);
      check("rd_rid_idle",    32'(bus.rid),    32'd0);
      check("rd_cnt1",        32'(rd_err_cnt), 32'd1);
      check("rd_arready_back", 32'(bus.arready), 32'd1);
      check("rd_addr",        last_err_addr,   32'h0000_1000);

      // 3: write burst ID=2 LEN=1, BREADY low for 3 cycles
      bus.awvalid = 1'b1; bus.awid = 8'h02; bus.awlen = 8'd1; bus.awaddr = 32'h0000_2000;
      tick();
      bus.awvalid = 1'b0;
      check("wr_wready", 32'(bus.wready), 32'd1);
      bus.wvalid = 1'b1; bus.wlast = 1'b0;
      tick();
      check("wr_bvalid_early", 32'(bus.bvalid), 32'd0);
      bus.wlast = 1'b1;
      tick();
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("wr_bvalid_hold%0d", i), 32'(bus.bvalid), 32'd1);
         check($sformatf("wr_bid_hold%0d", i),    32'(bus.bid),    32'h2);
         check($sformatf("wr_bresp_hold%0d", i),  32'(bus.bresp),  32'd3);
         tick();
      end
      check("wr_cnt_before_b", 32'(wr_err_cnt), 32'd0);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check("wr_bvalid_done", 32'(bus.bvalid), 32'd0);
      check("wr_cnt1",        32'(wr_err_cnt), 32'd1);
      check("wr_awready_back", 32'(bus.awready), 32'd1);
      check("wr_addr",        last_err_addr,   32'h0000_2000);

      // clear counters before the concurrent case
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr_rd", 32'(rd_err_cnt), 32'd0);
      check("clr_wr", 32'(wr_err_cnt), 32'd0);

      // 4: same-cycle AR and AW, LEN=0
      bus.arvalid = 1'b1; bus.arid = 8'h07; bus.arlen = 8'd0; bus.araddr = 32'h0000_3000;
      bus.awvalid = 1'b1; bus.awid = 8'h09; bus.awlen = 8'd0; bus.awaddr = 32'h0000_4000;
      bus.rready = 1'b1; bus.bready = 1'b1;
      tick();
      bus.arvalid = 1'b0; bus.awvalid = 1'b0;
      check("cc_addr",   last_err_addr,    32'h0000_3000);
      check("cc_rlast",  32'(bus.rlast),   32'd1);
      check("cc_rid",    32'(bus.rid),     32'h7);
      check("cc_wready", 32'(bus.wready),  32'd1);
      bus.wvalid = 1'b1; bus.wlast = 1'b1;
      tick();
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      check("cc_rvalid_done", 32'(bus.rvalid), 32'd0);
      check("cc_bvalid", 32'(bus.bvalid), 32'd1);
      check("cc_bid",    32'(bus.bid),    32'h9);
      tick();
      bus.bready = 1'b0;
      check("cc_rdcnt", 32'(rd_err_cnt), 32'd1);
      check("cc_wrcnt", 32'(wr_err_cnt), 32'd1);

      // 5a: AW LEN=3 with WLAST on beat 2
      bus.awvalid = 1'b1; bus.awid = 8'h04; bus.awlen = 8'd3; bus.awaddr = 32'h0000_5000;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b1; bus.wlast = 1'b0;
      tick();
      bus.wlast = 1'b1;
      tick();
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      check("ew_bvalid", 32'(bus.bvalid), 32'd1);
      check("ew_wready", 32'(bus.wready), 32'd0);
      check("ew_bid",    32'(bus.bid),    32'h4);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check("ew_wrcnt", 32'(wr_err_cnt), 32'd2);

      // 5b: reset during beat 3 of an 8-beat read
      bus.arvalid = 1'b1; bus.arid = 8'h01; bus.arlen = 8'd7; bus.araddr = 32'h0000_6000;
      bus.rready = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      tick(); tick(); tick();
      check("mr_rvalid_b3", 32'(bus.rvalid), 32'd1);
      check("mr_rlast_b3",  32'(bus.rlast),  32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_rvalid", 32'(bus.rvalid),  32'd0);
      check("mr_arready", 32'(bus.arready), 32'd1);
      check("mr_rid",    32'(bus.rid),     32'd0);
      check("mr_rdcnt",  32'(rd_err_cnt),  32'd0);

      // 6: saturate the 4-bit read counter with single-beat reads
      for (int i = 0; i < 16; i++) begin
         bus.arvalid = 1'b1; bus.arlen = 8'd0; bus.araddr = 32'(i);
         tick();
         bus.arvalid = 1'b0;
         tick();
         if (i == 14) check("sat_15", 32'(rd_err_cnt), 32'd15);
      end
      check("sat_hold", 32'(rd_err_cnt), 32'd15);
      // clear coincides with the completing beat
      bus.arvalid = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr_prio_rvalid", 32'(bus.rvalid), 32'd0);
      check("clr_prio", 32'(rd_err_cnt), 32'd0);

      // missing WLAST: LEN=1 finishes on the beat count
      bus.awvalid = 1'b1; bus.awid = 8'h0A; bus.awlen = 8'd1;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b1; bus.wlast = 1'b0;
      tick();
      tick();
      bus.wvalid = 1'b0;
      check("nolast_bvalid", 32'(bus.bvalid), 32'd1);
      check("nolast_bid",    32'(bus.bid),    32'h0A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
